// File: rtl/ppm_modulator_if.sv
// Symbol-side and pin-side signals of the 4-PPM slot generator.
// The shifter (master) drives symbol/valid; the modulator (slave) drives the pin and status.
interface ppm_modulator_if;
  logic [1:0] symbol;
  logic       symbol_valid;
  logic       ppm_out;
  logic       busy;
  logic       symbol_done;

  modport master (
    output symbol, symbol_valid,
    input  ppm_out, busy, symbol_done
  );

  modport slave (
    input  symbol, symbol_valid,
    output ppm_out, busy, symbol_done
  );
endinterface

// File: rtl/ppm_modulator.sv
// 4-PPM slot generator: one pulse per symbol period in the slot chosen by the symbol.
// Define PPM_GRAY_EN to Gray-map symbols to slots; otherwise symbol value = slot index.
module ppm_modulator #(
  parameter int SLOT_LEN  = 32,
  parameter int PULSE_LEN = 8,
  parameter int CNT_W     = 7
) (
  input  logic            clk,
  input  logic            rst,
  ppm_modulator_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 * SLOT_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sym_q;
  logic [1:0]       sym_sel;
  logic [1:0]       slot;
  logic [CNT_W-3:0] off;
  logic             active;
  logic             cnt_last;
  logic             pulse_d;
  logic             ppm_out_q;
  logic             done_q;

  function automatic logic [1:0] slot_map(input logic [1:0] s);
`ifdef PPM_GRAY_EN
    return {s[1], s[1] ^ s[0]};
`else
    return s;
`endif
  endfunction

  assign active   = (state_q != ST_IDLE);
  assign cnt_last = (cnt_q == CNT_LAST);
  assign slot     = cnt_q[CNT_W-1:CNT_W-2];
  assign off      = cnt_q[CNT_W-3:0];
  // The shifter's data_out is only valid from the first count of a period, so bypass the latch there.
  assign sym_sel  = (cnt_q == '0) ? bus.symbol : sym_q;
  assign pulse_d  = active && (slot == slot_map(sym_sel)) && (32'(off) < PULSE_LEN);

  always_comb begin
    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.symbol_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = bus.symbol_valid ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!bus.symbol_valid) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sym_q     <= '0;
      ppm_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (active && cnt_q == '0) sym_q <= bus.symbol;
      ppm_out_q <= pulse_d;
      done_q    <= active && cnt_last;
    end
  end

  assign bus.ppm_out     = ppm_out_q;
  assign bus.busy        = active;
  assign bus.symbol_done = done_q;

endmodule

// File: tb/tb_ppm_modulator.sv
// Scoreboard bench for ppm_modulator: stimulus pushes expected event cycles,
// a negedge monitor pops and compares whenever the DUT shows a pulse edge, done strobe or busy fall.
module tb_ppm_modulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_vec = 0;
  int n_bad = 0;

  int exp_rise[$];
  int exp_fall[$];
  int exp_done[$];
  int exp_bfall[$];

  logic ppm_prev  = 1'b0;
  logic busy_prev = 1'b0;

  ppm_modulator_if bus ();

  ppm_modulator #(
    .SLOT_LEN  (32),
    .PULSE_LEN (8),
    .CNT_W     (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int slot_of(input logic [1:0] s);
`ifdef PPM_GRAY_EN
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
`else
    return int'(s);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int kind, input string name);
    int e;
    bit have;
    e    = 0;
    have = 1'b0;
    case (kind)
      0: if (exp_rise.size()  > 0) begin e = exp_rise.pop_front();  have = 1'b1; end
      1: if (exp_fall.size()  > 0) begin e = exp_fall.pop_front();  have = 1'b1; end
      2: if (exp_done.size()  > 0) begin e = exp_done.pop_front();  have = 1'b1; end
      default: if (exp_bfall.size() > 0) begin e = exp_bfall.pop_front(); have = 1'b1; end
    endcase
    n_vec++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s: event at cycle %0d, none expected", name, cyc);
    end else if (e != cyc) begin
      n_bad++;
      $display("FAIL %s: seen at cycle %0d, expected cycle %0d", name, cyc, e);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.ppm_out === 1'b1 && ppm_prev === 1'b0)  expect_evt(0, "pulse_rise");
    if (bus.ppm_out === 1'b0 && ppm_prev === 1'b1)  expect_evt(1, "pulse_fall");
    if (bus.symbol_done === 1'b1)                   expect_evt(2, "symbol_done");
    if (bus.busy === 1'b0 && busy_prev === 1'b1)    expect_evt(3, "busy_fall");
    ppm_prev  = bus.ppm_out;
    busy_prev = bus.busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    check({name, "_queues_empty"},
          exp_rise.size() + exp_fall.size() + exp_done.size() + exp_bfall.size(), 0);
    check({name, "_busy_idle"}, int'(bus.busy), 0);
    check({name, "_ppm_low"}, int'(bus.ppm_out), 0);
  endtask

  // Drives one burst starting at T0 (current cycle) and pushes the hand-derived event cycles.
  task automatic run_seq(input string name, input logic [1:0] syms [8], input int n, input int valid_len);
    int t0;
    int rise;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      rise = t0 + 2 + 128 * i + 32 * slot_of(syms[i]);
      exp_rise.push_back(rise);
      exp_fall.push_back(rise + 8);
      exp_done.push_back(t0 + 129 + 128 * i);
    end
    exp_bfall.push_back(t0 + 1 + 128 * n);
    for (int c = 0; c < 128 * n + 4; c++) begin
      bus.symbol_valid = (c < valid_len);
      if (c == 0) bus.symbol = ~syms[0];
      else if ((c - 1) % 128 == 0 && (c - 1) / 128 < n) bus.symbol = syms[(c - 1) / 128];
      step();
    end
    bus.symbol_valid = 1'b0;
    check_drained(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] syms [8];
    int t0;

    // Reset held with symbol_valid high: outputs stay low.
    bus.symbol       = 2'b11;
    bus.symbol_valid = 1'b1;
    rst              = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ppm_out", int'(bus.ppm_out), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_symbol_done", int'(bus.symbol_done), 0);
    end
    rst              = 1'b0;
    bus.symbol_valid = 1'b0;
    step();
    check("post_rst_busy", int'(bus.busy), 0);

    // Byte 0xE4: symbols 00,01,10,11; valid falls exactly at cnt==last of period 4.
    syms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    run_seq("byte_e4", syms, 4, 512);

    // Two bytes back-to-back, no gap between periods.
    syms = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
    run_seq("two_bytes", syms, 8, 1024);

    // Valid falls at cnt==40: DRAIN completes the period, no second period.
    syms = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_seq("drain", syms, 1, 41);

    // One-cycle valid glitch in IDLE still emits a full period.
    syms = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_seq("glitch", syms, 1, 1);

    // Symbol 10: slot 2 in binary mapping, slot 3 with Gray mapping.
    syms = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_seq("sym_10", syms, 1, 128);

    // Reset at cnt==3 inside a slot-0 pulse aborts immediately.
    t0 = cyc;
    exp_rise.push_back(t0 + 2);
    exp_fall.push_back(t0 + 5);
    exp_bfall.push_back(t0 + 5);
    bus.symbol       = 2'b11;
    bus.symbol_valid = 1'b1;
    step();
    bus.symbol = 2'b00;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst              = 1'b0;
    bus.symbol_valid = 1'b0;
    check("abort_ppm_low", int'(bus.ppm_out), 0);
    check("abort_busy", int'(bus.busy), 0);
    for (int i = 0; i < 4; i++) step();
    check_drained("abort");

    // Fresh period after the abort proves the counter restarted from zero.
    syms = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_seq("after_abort", syms, 1, 128);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
